// File: rtl/responder_pkg.sv
// Shared definitions for the quiz responder arbiter: player count,
// arbiter state encoding and the lowest-index press selector.
package responder_pkg;

    localparam int PLAYER_CNT = 4;
    localparam int ID_W       = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        ANSWER  = 3'd2,
        TIMEOUT = 3'd3,
        FOUL    = 3'd4
    } state_t;

    // Lowest set bit wins when several contestants press in the same cycle.
    function automatic logic [ID_W-1:0] lowest_press(input logic [PLAYER_CNT-1:0] press);
        lowest_press = '0;
        for (int i = PLAYER_CNT - 1; i >= 0; i--) begin
            if (press[i]) lowest_press = ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus previous-value flop for one raw active-low key.
// press is a single-cycle pulse on the synchronized 1->0 transition.
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic sync1;
    logic sync2;
    logic prev;

    // Flops reset to the released level so reset release never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign press = prev & ~sync2;

endmodule

// File: rtl/responder_arbiter.sv
// Quiz responder arbiter: host arms a round, first contestant press wins,
// early presses are fouls, buzzer pulses on answer or foul.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   IDLE    | waiting for host start; any contestant press fouls
//   ARMED   | countdown running, first contestant press answers
//   ANSWER  | winner latched, buzzer pulse, waiting for clear
//   TIMEOUT | countdown expired with no press, waiting for clear
//   FOUL    | early presser latched, buzzer pulse, waiting for clear
module responder_arbiter
    import responder_pkg::*;
#(
    parameter int BUZZ_CYCLES = 25_000_000,
    parameter int N_PLAYERS   = PLAYER_CNT
) (
    input  logic                  CLK,
    input  logic                  Rst,
    input  logic                  Host_Start_n,
    input  logic                  Host_Clear_n,
    input  logic [PLAYER_CNT-1:0] Key_n,
    input  logic                  Time_Over,
    output logic                  Timer_Start,
    output logic [ID_W-1:0]       Winner_ID,
    output logic                  Winner_Valid,
    output logic                  Foul,
    output logic [PLAYER_CNT-1:0] LED_Player,
    output logic                  Buzzer
);

    localparam int CNT_W = (BUZZ_CYCLES < 1) ? 1 : $clog2(BUZZ_CYCLES + 1);
    localparam logic [CNT_W-1:0] BUZZ_LOAD = CNT_W'(BUZZ_CYCLES);

    logic [PLAYER_CNT-1:0] key_press;
    logic                  start_press;
    logic                  clear_press;

    state_t          state;
    state_t          state_nxt;
    logic            latch;
    logic [ID_W-1:0] latch_id;
    logic [ID_W-1:0] id_nxt;
    logic            holding;
    logic            buzz_start;
    logic [CNT_W-1:0] buzz_cnt;

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_key
        key_sync_edge u_key (
            .clk   (CLK),
            .rst   (Rst),
            .key_n (Key_n[i]),
            .press (key_press[i])
        );
    end

    key_sync_edge u_start (
        .clk   (CLK),
        .rst   (Rst),
        .key_n (Host_Start_n),
        .press (start_press)
    );

    key_sync_edge u_clear (
        .clk   (CLK),
        .rst   (Rst),
        .key_n (Host_Clear_n),
        .press (clear_press)
    );

    // Next state and winner latch; clear overrides everything, a press beats Time_Over.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        latch_id  = lowest_press(key_press);
        if (clear_press) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (|key_press) begin
                        state_nxt = FOUL;
                        latch     = 1'b1;
                    end else if (start_press) begin
                        state_nxt = ARMED;
                    end
                end
                ARMED: begin
                    if (|key_press) begin
                        state_nxt = ANSWER;
                        latch     = 1'b1;
                    end else if (Time_Over) begin
                        state_nxt = TIMEOUT;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    assign id_nxt     = latch ? latch_id : Winner_ID;
    assign holding    = (state_nxt == ANSWER) || (state_nxt == FOUL);
    assign buzz_start = holding && (state_nxt != state);

    // State register and registered outputs, all derived from the next state.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            Timer_Start  <= 1'b0;
            Winner_ID    <= '0;
            Winner_Valid <= 1'b0;
            Foul         <= 1'b0;
            LED_Player   <= '0;
        end else begin
            state        <= state_nxt;
            Timer_Start  <= (state_nxt == ARMED);
            Winner_ID    <= id_nxt;
            Winner_Valid <= (state_nxt == ANSWER);
            Foul         <= (state_nxt == FOUL);
            LED_Player   <= holding ? (PLAYER_CNT'(1) << id_nxt) : '0;
        end
    end

    // Buzzer pulse: loaded on entry to ANSWER/FOUL, cut short by any return to IDLE.
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            buzz_cnt <= '0;
            Buzzer   <= 1'b0;
        end else if (state_nxt == IDLE) begin
            buzz_cnt <= '0;
            Buzzer   <= 1'b0;
        end else if (buzz_start) begin
            buzz_cnt <= BUZZ_LOAD;
            Buzzer   <= (BUZZ_CYCLES != 0);
        end else if (buzz_cnt != '0) begin
            buzz_cnt <= buzz_cnt - CNT_W'(1);
            Buzzer   <= (buzz_cnt != CNT_W'(1));
        end
    end

endmodule

// File: doc/responder_arbiter.md
RESPONDER_ARBITER -- requirements
Module: responder_arbiter

Interface
REQ-001 SHALL have parameter BUZZ_CYCLES, default 25_000_000, meaning buzzer pulse length in CLK cycles (0.5 s at 50 MHz).
REQ-002 SHALL have parameter N_PLAYERS, default 4, meaning contestant key count; fixed at 4 in this revision.
REQ-003 SHALL have port CLK  input  1  system clock, 50 MHz.
REQ-004 SHALL have port Rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port Host_Start_n  input  1  raw host "start round" key, active-low.
REQ-006 SHALL have port Host_Clear_n  input  1  raw host "clear" key, active-low.
REQ-007 SHALL have port Key_n  input  4  raw contestant keys, active-low, bit i = player i.
REQ-008 SHALL have port Time_Over  input  1  high while the countdown timer reads 00.
REQ-009 SHALL have port Timer_Start  output  1  level enabling the countdown timer.
REQ-010 SHALL have port Winner_ID  output  2  index of the latched answering or fouling player.
REQ-011 SHALL have port Winner_Valid  output  1  high in ANSWER.
REQ-012 SHALL have port Foul  output  1  high in FOUL.
REQ-013 SHALL have port LED_Player  output  4  one-hot player LED, bit Winner_ID set in ANSWER or FOUL, else 0.
REQ-014 SHALL have port Buzzer  output  1  active-high buzzer drive.

Function
REQ-015 SHALL pass every raw key through a 2-flop synchronizer plus previous-value flop; a press is the synchronized 1->0 edge, a single-cycle event.
REQ-016 SHALL update registered outputs on the 2nd rising CLK edge after the edge that first samples a key low.
REQ-017 SHALL implement states IDLE, ARMED, ANSWER, TIMEOUT, FOUL; all outputs registered.
REQ-018 IDLE: Timer_Start=0; Host_Start press -> ARMED; contestant press -> FOUL with that ID latched.
REQ-019 ARMED: Timer_Start=1; contestant press -> ANSWER with ID latched, Timer_Start=0 on the same edge; Time_Over=1 with no press -> TIMEOUT.
REQ-020 ARMED: contestant press and Time_Over in the same cycle -> ANSWER (press wins).
REQ-021 Simultaneous contestant presses: lowest index wins; other presses ignored.
REQ-022 ANSWER, TIMEOUT, FOUL: Timer_Start=0; all contestant and Host_Start presses ignored; Host_Clear press -> IDLE.
REQ-023 Host_Clear press in any state -> IDLE, with priority over Host_Start and contestant presses in the same cycle.
REQ-024 Host_Start press outside IDLE SHALL be ignored.
REQ-025 On entry to ANSWER or FOUL, Buzzer SHALL be high for exactly BUZZ_CYCLES cycles; counter width = clog2(BUZZ_CYCLES+1).
REQ-026 A transition to IDLE during a buzzer pulse SHALL drop Buzzer and clear the counter on that edge.
REQ-027 TIMEOUT SHALL NOT drive Buzzer; the timer sounds its own.
REQ-028 Winner_ID SHALL hold its value until the next latch; it is 0 after reset.

Reset
REQ-029 Rst high SHALL immediately force IDLE, Timer_Start=0, Winner_ID=0, Winner_Valid=0, Foul=0, LED_Player=0, Buzzer=0, buzzer counter=0.
REQ-030 Synchronizer flops SHALL reset to 1 (keys released), so that no press is generated on reset release.
REQ-031 Reset mid-round SHALL discard the latched winner; the first press after release is evaluated from IDLE.

Structure
REQ-032 The state encoding enum and the player-count constant SHALL reside in shared package responder_pkg.
REQ-033 Synchronizer plus edge detect SHALL be sub-module key_sync_edge (1 bit, instantiated 6 times).

Verification (BUZZ_CYCLES=4)
REQ-034 Reset, Host_Start_n low 3 cycles -> Timer_Start=1; then Key_n=4'b1011 -> Winner_ID=2, LED_Player=4'b0100, Winner_Valid=1, Timer_Start=0, Buzzer high exactly 4 cycles.
REQ-035 In ARMED, Key_n 4'b1111->4'b0101 in one cycle -> Winner_ID=1; a later Key_n bit-0 press -> no change.
REQ-036 In IDLE, Key_n=4'b0111 -> Foul=1, Winner_ID=3, LED_Player=4'b1000, Buzzer 4 cycles; Host_Start ignored until Host_Clear.
REQ-037 In ARMED, Time_Over=1, no keys -> TIMEOUT, Timer_Start=0, Buzzer=0; Host_Clear -> IDLE, all outputs 0 except Winner_ID.
REQ-038 In ARMED, press Key_n bit 0 in the same cycle as Time_Over rises -> ANSWER, Winner_ID=0.
REQ-039 Assert Rst during a buzzer pulse -> Buzzer=0 and IDLE immediately; Host_Clear press coincident with a contestant press in ARMED -> IDLE, no latch.
